// File: rtl/cga_pkg.sv
// -----------------------------------------------------------------------------
// cga_pkg
// Shared definitions for the CGA VRAM arbiter slice:
//   - arbiter FSM state encoding
//   - VRAM / CPU-window address widths
//   - helper that folds a CPU offset into the 16K or 32K VRAM window
// -----------------------------------------------------------------------------
package cga_pkg;

  localparam int VRAM_AW    = 19;  // VRAM address width
  localparam int CPU_AW     = 15;  // CPU offset width inside the B8000 window
  localparam int WIN_16K_AW = 14;  // standard CGA: 16K of VRAM
  localparam int WIN_32K_AW = 15;  // Tandy: 32K of VRAM

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_ACCESS    = 2'd2,
    ST_DONE      = 2'd3
  } arb_state_t;

  // Fold a CPU window offset into VRAM: the 16K part mirrors every 16K.
  function automatic logic [CPU_AW-1:0] cpu_offset(input logic [CPU_AW-1:0] a,
                                                   input logic              vram_32k);
    logic [CPU_AW-1:0] r;
    if (vram_32k) begin
      r = a[WIN_32K_AW-1:0];
    end else begin
      r = {1'b0, a[WIN_16K_AW-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/cga_bus_sync.sv
// -----------------------------------------------------------------------------
// cga_bus_sync
// Two-flop synchronizer for an active-low ISA strobe. Resets to 1 so that
// an idle (deasserted) strobe is what the core sees out of reset.
// Ports:
//   clk      in  system clock
//   reset_l  in  asynchronous active-low reset
//   i_async  in  asynchronous strobe
//   o_sync   out strobe synchronized to clk (2-clock latency)
// -----------------------------------------------------------------------------
module cga_bus_sync (
  input  logic clk,
  input  logic reset_l,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous strobe
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/cga_vram_arbiter.sv
// -----------------------------------------------------------------------------
// cga_vram_arbiter
// Owns the single 8-bit VRAM port shared between ISA CPU memory cycles in the
// B8000 window and CGA video fetches. Video fetch addresses pass straight
// through; a CPU access is inserted only in a sequencer-granted ISA slot, and
// bus_rdy holds the CPU in wait states until its access is complete.
// Ports:
//   clk, reset_l             clock, asynchronous active-low reset
//   bus_a, bus_d             CPU window offset and write data
//   bus_memr_l, bus_memw_l   ISA memory strobes (async, active low)
//   bus_mem_cs               window decode, 1 = selected
//   isa_op_enable            sequencer: CPU slot open this clock
//   vram_read                sequencer: video fetch in progress
//   vid_a                    video fetch address from the CGA core
//   ram_d                    VRAM read data
//   ram_a                    VRAM address (CPU address during ACCESS, else vid_a)
//   ram_d_out, ram_d_oe      VRAM write data and its output enable
//   ram_we_l                 VRAM write enable, active low
//   bus_out_mem              latched CPU read data
//   bus_dir_mem              1 = CPU memory read in progress
//   bus_rdy                  ISA ready, 0 = wait state
//   vid_conflict             one-clock pulse: video fetch hit a CPU access
// -----------------------------------------------------------------------------
module cga_vram_arbiter
  import cga_pkg::*;
#(
  parameter int USE_BUS_WAIT  = 1,
  parameter int ACCESS_CYCLES = 2,
  parameter int VRAM_32K      = 0
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic [CPU_AW-1:0]  bus_a,
  input  logic [7:0]         bus_d,
  input  logic               bus_memr_l,
  input  logic               bus_memw_l,
  input  logic               bus_mem_cs,
  input  logic               isa_op_enable,
  input  logic               vram_read,
  input  logic [VRAM_AW-1:0] vid_a,
  input  logic [7:0]         ram_d,
  output logic [VRAM_AW-1:0] ram_a,
  output logic [7:0]         ram_d_out,
  output logic               ram_d_oe,
  output logic               ram_we_l,
  output logic [7:0]         bus_out_mem,
  output logic               bus_dir_mem,
  output logic               bus_rdy,
  output logic               vid_conflict
);

  // Counter load value: the counter reaches 0 on the last ACCESS clock.
  localparam logic [1:0] CNT_LOAD    = 2'(ACCESS_CYCLES - 1);
  localparam logic       BUS_WAIT_EN = (USE_BUS_WAIT != 0);
  localparam logic       IS_32K      = (VRAM_32K != 0);

  logic w_memr_s;
  logic w_memw_s;
  logic w_rd_req;
  logic w_wr_req;
  logic w_req_active;

  arb_state_t        r_state;
  logic              r_is_write;
  logic [CPU_AW-1:0] r_cpu_addr;
  logic [7:0]        r_cpu_data;
  logic [1:0]        r_cnt;
  logic              r_conflict_seen;
  logic              r_ram_we_l;
  logic              r_ram_d_oe;
  logic              r_bus_rdy;
  logic [7:0]        r_bus_out_mem;
  logic              r_bus_dir_mem;
  logic              r_vid_conflict;

  cga_bus_sync u_sync_memr (
    .clk     (clk),
    .reset_l (reset_l),
    .i_async (bus_memr_l),
    .o_sync  (w_memr_s)
  );

  cga_bus_sync u_sync_memw (
    .clk     (clk),
    .reset_l (reset_l),
    .i_async (bus_memw_l),
    .o_sync  (w_memw_s)
  );

  assign w_rd_req = bus_mem_cs & ~w_memr_s;
  assign w_wr_req = bus_mem_cs & ~w_memw_s;

  // The strobe that belongs to the latched operation keeps the request alive.
  assign w_req_active = r_is_write ? w_wr_req : w_rd_req;

  // Arbiter FSM with access counter, CPU latches and registered port controls
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state         <= ST_IDLE;
      r_is_write      <= 1'b0;
      r_cpu_addr      <= '0;
      r_cpu_data      <= 8'h00;
      r_cnt           <= 2'd0;
      r_conflict_seen <= 1'b0;
      r_ram_we_l      <= 1'b1;
      r_ram_d_oe      <= 1'b0;
      r_bus_rdy       <= 1'b1;
      r_bus_out_mem   <= 8'h00;
      r_bus_dir_mem   <= 1'b0;
      r_vid_conflict  <= 1'b0;
    end else begin
      r_bus_dir_mem  <= w_rd_req;
      r_vid_conflict <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ram_we_l <= 1'b1;
          r_ram_d_oe <= 1'b0;
          if (w_rd_req | w_wr_req) begin
            r_state    <= ST_WAIT_SLOT;
            // A write strobe wins over a simultaneous read strobe.
            r_is_write <= w_wr_req;
            r_cpu_addr <= cpu_offset(bus_a, IS_32K);
            r_cpu_data <= bus_d;
            r_bus_rdy  <= ~BUS_WAIT_EN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT_SLOT: begin
          if (!w_req_active) begin
            // CPU gave up before a slot opened: no RAM cycle at all.
            r_state   <= ST_IDLE;
            r_bus_rdy <= 1'b1;
          end else if (isa_op_enable & ~vram_read) begin
            r_state         <= ST_ACCESS;
            r_cnt           <= CNT_LOAD;
            r_ram_d_oe      <= r_is_write;
            r_ram_we_l      <= ~r_is_write;
            r_conflict_seen <= 1'b0;
          end else begin
            r_state <= ST_WAIT_SLOT;
          end
        end
        ST_ACCESS: begin
          // The CPU keeps the port; a colliding fetch is only flagged once.
          if (vram_read & ~r_conflict_seen) begin
            r_vid_conflict  <= 1'b1;
            r_conflict_seen <= 1'b1;
          end else begin
            r_conflict_seen <= r_conflict_seen;
          end
          if (r_cnt == 2'd0) begin
            r_state    <= ST_DONE;
            r_bus_rdy  <= 1'b1;
            r_ram_we_l <= 1'b1;
            r_ram_d_oe <= 1'b0;
            if (!r_is_write) begin
              r_bus_out_mem <= ram_d;
            end else begin
              r_bus_out_mem <= r_bus_out_mem;
            end
          end else begin
            r_cnt <= r_cnt - 2'd1;
            // Release WE one clock early so address and data hold past it.
            if (r_cnt == 2'd1) begin
              r_ram_we_l <= 1'b1;
            end else begin
              r_ram_we_l <= r_ram_we_l;
            end
          end
        end
        ST_DONE: begin
          r_ram_we_l <= 1'b1;
          r_ram_d_oe <= 1'b0;
          if (!w_req_active) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_ram_we_l <= 1'b1;
          r_ram_d_oe <= 1'b0;
          r_bus_rdy  <= 1'b1;
        end
      endcase
    end
  end

  // Port mux: the CPU owns the address bus only while in ACCESS.
  assign ram_a        = (r_state == ST_ACCESS) ? {4'h0, r_cpu_addr} : vid_a;
  assign ram_d_out    = r_cpu_data;
  assign ram_d_oe     = r_ram_d_oe;
  assign ram_we_l     = r_ram_we_l;
  assign bus_out_mem  = r_bus_out_mem;
  assign bus_dir_mem  = r_bus_dir_mem;
  assign bus_rdy      = r_bus_rdy;
  assign vid_conflict = r_vid_conflict;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
module tb_cga_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [14:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_mem_cs;
  logic        isa_op_enable;
  logic        vram_read;
  logic [18:0] vid_a;
  logic [7:0]  ram_d;

  logic [18:0] ram_a;
  logic [7:0]  ram_d_out;
  logic        ram_d_oe;
  logic        ram_we_l;
  logic [7:0]  bus_out_mem;
  logic        bus_dir_mem;
  logic        bus_rdy;
  logic        vid_conflict;

  logic [18:0] ram_a_b;
  logic [7:0]  ram_d_out_b;
  logic        ram_d_oe_b;
  logic        ram_we_l_b;
  logic [7:0]  bus_out_mem_b;
  logic        bus_dir_mem_b;
  logic        bus_rdy_b;
  logic        vid_conflict_b;

  logic [7:0]  mem [0:1023];

  int tests_run    = 0;
  int tests_failed = 0;
  int we_cnt       = 0;
  int conf_cnt     = 0;
  logic [18:0] we_addr = 19'h0;
  logic [7:0]  we_data = 8'h00;

  always #5 clk = ~clk;

  assign ram_d = mem[ram_a[9:0]];

  cga_vram_arbiter #(.USE_BUS_WAIT(1), .ACCESS_CYCLES(2), .VRAM_32K(0)) dut (
    .clk(clk), .reset_l(reset_l), .bus_a(bus_a), .bus_d(bus_d),
    .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_mem_cs(bus_mem_cs),
    .isa_op_enable(isa_op_enable), .vram_read(vram_read), .vid_a(vid_a), .ram_d(ram_d),
    .ram_a(ram_a), .ram_d_out(ram_d_out), .ram_d_oe(ram_d_oe), .ram_we_l(ram_we_l),
    .bus_out_mem(bus_out_mem), .bus_dir_mem(bus_dir_mem), .bus_rdy(bus_rdy),
    .vid_conflict(vid_conflict)
  );

  cga_vram_arbiter #(.USE_BUS_WAIT(1), .ACCESS_CYCLES(2), .VRAM_32K(1)) dut32 (
    .clk(clk), .reset_l(reset_l), .bus_a(bus_a), .bus_d(bus_d),
    .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_mem_cs(bus_mem_cs),
    .isa_op_enable(isa_op_enable), .vram_read(vram_read), .vid_a(vid_a), .ram_d(ram_d),
    .ram_a(ram_a_b), .ram_d_out(ram_d_out_b), .ram_d_oe(ram_d_oe_b), .ram_we_l(ram_we_l_b),
    .bus_out_mem(bus_out_mem_b), .bus_dir_mem(bus_dir_mem_b), .bus_rdy(bus_rdy_b),
    .vid_conflict(vid_conflict_b)
  );

  // Write-strobe and conflict monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (reset_l === 1'b1 && ram_we_l === 1'b0) begin
      we_cnt++;
      we_addr = ram_a;
      we_data = ram_d_out;
    end
    if (vid_conflict === 1'b1) conf_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a CPU cycle and wait until it reaches WAIT_SLOT (2 sync + 1)
  task automatic start_cpu(input logic rd, input logic wr, input logic [14:0] a, input logic [7:0] d);
    bus_a      = a;
    bus_d      = d;
    bus_mem_cs = 1'b1;
    bus_memr_l = ~rd;
    bus_memw_l = ~wr;
    repeat (3) tick();
  endtask

  task automatic grant();
    isa_op_enable = 1'b1;
    tick();
    isa_op_enable = 1'b0;
  endtask

  task automatic release_cpu();
    bus_memr_l = 1'b1;
    bus_memw_l = 1'b1;
    bus_mem_cs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_l = 1'b0; bus_a = 15'h0; bus_d = 8'h00; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
    bus_mem_cs = 1'b0; isa_op_enable = 1'b0; vram_read = 1'b0; vid_a = 19'h7ABCD;
    repeat (3) tick();
    tests_run++; if (ram_we_l !== 1'b1) begin tests_failed++; $display("FAIL reset_we_l: got %b expected 1", ram_we_l); end
    tests_run++; if (ram_d_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe: got %b expected 0", ram_d_oe); end
    tests_run++; if (bus_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy: got %b expected 1", bus_rdy); end
    tests_run++; if (bus_out_mem !== 8'h00) begin tests_failed++; $display("FAIL reset_out_mem: got %h expected 00", bus_out_mem); end
    tests_run++; if (vid_conflict !== 1'b0) begin tests_failed++; $display("FAIL reset_conflict: got %b expected 0", vid_conflict); end
    tests_run++; if (bus_dir_mem !== 1'b0) begin tests_failed++; $display("FAIL reset_dir: got %b expected 0", bus_dir_mem); end
    tests_run++; if (ram_a !== 19'h7ABCD) begin tests_failed++; $display("FAIL reset_ram_a: got %h expected 7abcd", ram_a); end
    reset_l = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_write();
    int we0;
    we0 = we_cnt;
    bus_a = 15'h0123; bus_d = 8'hA5; bus_mem_cs = 1'b1; bus_memw_l = 1'b0;
    repeat (2) tick();
    tests_run++; if (bus_rdy !== 1'b1) begin tests_failed++; $display("FAIL wr_rdy_sync: got %b expected 1", bus_rdy); end
    tick();
    tests_run++; if (bus_rdy !== 1'b0) begin tests_failed++; $display("FAIL wr_rdy_wait: got %b expected 0", bus_rdy); end
    grant();
    tests_run++; if (ram_a !== 19'h00123) begin tests_failed++; $display("FAIL wr_addr: got %h expected 00123", ram_a); end
    tests_run++; if (ram_we_l !== 1'b0) begin tests_failed++; $display("FAIL wr_we_first: got %b expected 0", ram_we_l); end
    tests_run++; if (ram_d_oe !== 1'b1 || ram_d_out !== 8'hA5) begin tests_failed++; $display("FAIL wr_data: got oe=%b d=%h expected oe=1 d=a5", ram_d_oe, ram_d_out); end
    tick();
    tests_run++; if (ram_we_l !== 1'b1 || ram_d_oe !== 1'b1 || ram_a !== 19'h00123) begin tests_failed++; $display("FAIL wr_hold: got we_l=%b oe=%b a=%h expected 1 1 00123", ram_we_l, ram_d_oe, ram_a); end
    tests_run++; if (bus_rdy !== 1'b0) begin tests_failed++; $display("FAIL wr_rdy_access: got %b expected 0", bus_rdy); end
    tick();
    tests_run++; if (bus_rdy !== 1'b1 || ram_d_oe !== 1'b0 || ram_a !== 19'h7ABCD) begin tests_failed++; $display("FAIL wr_done: got rdy=%b oe=%b a=%h expected 1 0 7abcd", bus_rdy, ram_d_oe, ram_a); end
    tests_run++; if (we_cnt - we0 !== 1 || we_addr !== 19'h00123 || we_data !== 8'hA5) begin tests_failed++; $display("FAIL wr_strobe: got n=%0d a=%h d=%h expected 1 00123 a5", we_cnt - we0, we_addr, we_data); end
    release_cpu();
  endtask

  task automatic test_read();
    int we0;
    we0 = we_cnt;
    mem[16] = 8'h3C;
    start_cpu(1'b1, 1'b0, 15'h0010, 8'h00);
    tests_run++; if (bus_rdy !== 1'b0 || bus_dir_mem !== 1'b1) begin tests_failed++; $display("FAIL rd_wait: got rdy=%b dir=%b expected 0 1", bus_rdy, bus_dir_mem); end
    grant();
    tests_run++; if (ram_a !== 19'h00010 || ram_d_oe !== 1'b0) begin tests_failed++; $display("FAIL rd_access: got a=%h oe=%b expected 00010 0", ram_a, ram_d_oe); end
    tick();
    tests_run++; if (bus_out_mem !== 8'h00 || bus_rdy !== 1'b0) begin tests_failed++; $display("FAIL rd_early: got d=%h rdy=%b expected 00 0", bus_out_mem, bus_rdy); end
    tick();
    tests_run++; if (bus_rdy !== 1'b1 || bus_out_mem !== 8'h3C) begin tests_failed++; $display("FAIL rd_data: got rdy=%b d=%h expected 1 3c", bus_rdy, bus_out_mem); end
    tests_run++; if (we_cnt !== we0) begin tests_failed++; $display("FAIL rd_no_we: got %0d write strobes expected 0", we_cnt - we0); end
    release_cpu();
    tests_run++; if (bus_dir_mem !== 1'b0 || bus_out_mem !== 8'h3C) begin tests_failed++; $display("FAIL rd_after: got dir=%b d=%h expected 0 3c", bus_dir_mem, bus_out_mem); end
  endtask

  task automatic test_abort();
    int we0, bad, n;
    logic saw_low, saw_oe;
    we0 = we_cnt; bad = 0; n = 0; saw_low = 1'b0; saw_oe = 1'b0;
    bus_a = 15'h0030; bus_mem_cs = 1'b1; bus_memr_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vid_a = 19'h10000 + 19'(i);
      tick();
      if (ram_a !== vid_a) bad++;
      if (bus_rdy === 1'b0) saw_low = 1'b1;
      if (ram_d_oe === 1'b1) saw_oe = 1'b1;
    end
    bus_memr_l = 1'b1;
    while (bus_rdy !== 1'b1 && n < 10) begin
      vid_a = vid_a + 19'd1;
      tick();
      n++;
      if (ram_a !== vid_a) bad++;
      if (ram_d_oe === 1'b1) saw_oe = 1'b1;
    end
    tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL abort_rdy_return: got %0d clocks expected 3", n); end
    tests_run++; if (saw_low !== 1'b1) begin tests_failed++; $display("FAIL abort_rdy_low: got %b expected 1", saw_low); end
    tests_run++; if (bad !== 0 || saw_oe !== 1'b0) begin tests_failed++; $display("FAIL abort_port: got %0d addr misses oe=%b expected 0 0", bad, saw_oe); end
    tests_run++; if (we_cnt !== we0) begin tests_failed++; $display("FAIL abort_no_we: got %0d strobes expected 0", we_cnt - we0); end
    vid_a = 19'h7ABCD;
    release_cpu();
  endtask

  task automatic test_wrap();
    start_cpu(1'b0, 1'b1, 15'h4005, 8'h11);
    grant();
    tests_run++; if (ram_a !== 19'h00005) begin tests_failed++; $display("FAIL wrap_16k: got %h expected 00005", ram_a); end
    tests_run++; if (ram_a_b !== 19'h04005) begin tests_failed++; $display("FAIL wrap_32k: got %h expected 04005", ram_a_b); end
    repeat (2) tick();
    release_cpu();
  endtask

  task automatic test_conflict();
    int c0;
    c0 = conf_cnt;
    start_cpu(1'b0, 1'b1, 15'h0200, 8'h77);
    vram_read = 1'b1; isa_op_enable = 1'b1;
    repeat (2) tick();
    tests_run++; if (ram_a !== 19'h7ABCD || bus_rdy !== 1'b0) begin tests_failed++; $display("FAIL slot_blocked: got a=%h rdy=%b expected 7abcd 0", ram_a, bus_rdy); end
    vram_read = 1'b0;
    tick();
    isa_op_enable = 1'b0;
    tests_run++; if (ram_a !== 19'h00200) begin tests_failed++; $display("FAIL cf_access1: got %h expected 00200", ram_a); end
    tick();
    vram_read = 1'b1;
    tests_run++; if (ram_a !== 19'h00200 || vid_conflict !== 1'b0) begin tests_failed++; $display("FAIL cf_access2: got a=%h cf=%b expected 00200 0", ram_a, vid_conflict); end
    tick();
    tests_run++; if (vid_conflict !== 1'b1 || bus_rdy !== 1'b1) begin tests_failed++; $display("FAIL cf_pulse: got cf=%b rdy=%b expected 1 1", vid_conflict, bus_rdy); end
    repeat (2) tick();
    tests_run++; if (conf_cnt - c0 !== 1) begin tests_failed++; $display("FAIL cf_count: got %0d pulses expected 1", conf_cnt - c0); end
    vram_read = 1'b0;
    release_cpu();
  endtask

  task automatic test_simul();
    int we0;
    we0 = we_cnt;
    start_cpu(1'b1, 1'b1, 15'h0040, 8'h99);
    grant();
    tests_run++; if (ram_we_l !== 1'b0 || ram_d_oe !== 1'b1) begin tests_failed++; $display("FAIL simul_write: got we_l=%b oe=%b expected 0 1", ram_we_l, ram_d_oe); end
    repeat (2) tick();
    tests_run++; if (bus_rdy !== 1'b1 || bus_out_mem !== 8'h3C || we_cnt - we0 !== 1) begin tests_failed++; $display("FAIL simul_done: got rdy=%b d=%h n=%0d expected 1 3c 1", bus_rdy, bus_out_mem, we_cnt - we0); end
    release_cpu();
  endtask

  task automatic test_reset_mid();
    start_cpu(1'b0, 1'b1, 15'h0055, 8'hEE);
    grant();
    tests_run++; if (ram_we_l !== 1'b0) begin tests_failed++; $display("FAIL rm_pre: got we_l=%b expected 0", ram_we_l); end
    #1 reset_l = 1'b0;
    #1;
    tests_run++; if (ram_we_l !== 1'b1 || ram_d_oe !== 1'b0 || bus_rdy !== 1'b1) begin tests_failed++; $display("FAIL rm_drop: got we_l=%b oe=%b rdy=%b expected 1 0 1", ram_we_l, ram_d_oe, bus_rdy); end
    tests_run++; if (ram_a !== 19'h7ABCD) begin tests_failed++; $display("FAIL rm_addr: got %h expected 7abcd", ram_a); end
    bus_memw_l = 1'b1; bus_mem_cs = 1'b0;
    tick();
    reset_l = 1'b1;
    tick();
    mem[33] = 8'h5A;
    start_cpu(1'b1, 1'b0, 15'h0021, 8'h00);
    grant();
    repeat (2) tick();
    tests_run++; if (bus_rdy !== 1'b1 || bus_out_mem !== 8'h5A) begin tests_failed++; $display("FAIL rm_read: got rdy=%b d=%h expected 1 5a", bus_rdy, bus_out_mem); end
    release_cpu();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_wrap();
    test_conflict();
    test_simul();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
